align_shift_controller: RTL

ALIGN_SHIFT_CONTROLLER -- requirements
Module: align_shift_controller

---
 rtl/align_shift_controller.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/align_shift_controller.sv
`default_nettype none
// ============================================================================
// Module   : align_shift_controller
// Purpose  : Half-precision operand alignment sequencer. Captures an operand
//            pair, selects the larger-magnitude operand, drives an external
//            11-bit right barrel shifter with the smaller significand and the
//            exponent difference, and presents the aligned pair with a
//            sticky bit on a valid/ready output handshake.
// Ports    : clk, rst_n        - clock, synchronous active-low reset
//            in_valid/in_ready - operand pair handshake (a_*, b_*)
//            sh_in/sh_ctrl     - data/amount to external shifter
//            sh_out            - shifter result (combinational from sh_in/ctrl)
//            out_valid/out_ready - result handshake
//            big_mant, small_mant, exp_out, swapped, sticky - result
// Revision : 1.0 - initial release
// ============================================================================
module align_shift_controller (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  a_exp,
    input  logic [10:0] a_mant,
    input  logic [4:0]  b_exp,
    input  logic [10:0] b_mant,
    output logic [10:0] sh_in,
    output logic [4:0]  sh_ctrl,
    input  logic [10:0] sh_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [10:0] big_mant,
    output logic [10:0] small_mant,
    output logic [4:0]  exp_out,
    output logic        swapped,
    output logic        sticky
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CMP   = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam logic [4:0] c_MANT_W = 5'd11;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;

    // Captured operands
    logic [4:0]  r_a_exp;
    logic [10:0] r_a_mant;
    logic [4:0]  r_b_exp;
    logic [10:0] r_b_mant;

    // Compare-stage results
    logic        r_swap;
    logic [4:0]  r_big_exp;
    logic [10:0] r_big_mant;
    logic [10:0] r_small_mant;
    logic [4:0]  r_diff;

    // Result registers
    logic [10:0] r_out_big;
    logic [10:0] r_out_small;
    logic [4:0]  r_out_exp;
    logic        r_out_swapped;
    logic        r_out_sticky;

    logic        w_transfer;
    logic        w_swap;
    logic [4:0]  w_diff;
    logic [10:0] w_sticky_mask;
    logic        w_sticky;
    logic [10:0] w_aligned;

    assign w_transfer = in_valid && (r_state == S_IDLE);

    // Magnitude compare: exponent first, significand breaks exponent ties.
    // Equal operands leave A as the larger one.
    assign w_swap = (r_b_exp > r_a_exp) ||
                    ((r_b_exp == r_a_exp) && (r_b_mant > r_a_mant));
    assign w_diff = w_swap ? (r_b_exp - r_a_exp) : (r_a_exp - r_b_exp);

    // Mask of bit positions below min(diff, 11): these are the bits the
    // shifter discards. diff <= 10 in the shifted branch, so no overflow.
    always_comb begin
        w_sticky_mask = 11'h7FF;
        if (r_diff < c_MANT_W) begin
            w_sticky_mask = (11'd1 << r_diff) - 11'd1;
        end
    end

    assign w_sticky  = |(r_small_mant & w_sticky_mask);
    // Shifts of 11 or more flush the significand regardless of how the
    // external shifter treats out-of-range amounts.
    assign w_aligned = (r_diff >= c_MANT_W) ? 11'd0 : sh_out;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_next_state = S_CMP;
            S_CMP:                  w_next_state = S_SHIFT;
            S_SHIFT:                w_next_state = S_HOLD;
            S_HOLD:  if (out_ready) w_next_state = S_IDLE;
            default:                w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from the registered state only
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        sh_in     = 11'd0;
        sh_ctrl   = 5'd0;
        case (r_state)
            S_IDLE:  in_ready  = 1'b1;
            S_SHIFT: begin
                sh_in   = r_small_mant;
                sh_ctrl = r_diff;
            end
            S_HOLD:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_exp       <= 5'd0;
            r_a_mant      <= 11'd0;
            r_b_exp       <= 5'd0;
            r_b_mant      <= 11'd0;
            r_swap        <= 1'b0;
            r_big_exp     <= 5'd0;
            r_big_mant    <= 11'd0;
            r_small_mant  <= 11'd0;
            r_diff        <= 5'd0;
            r_out_big     <= 11'd0;
            r_out_small   <= 11'd0;
            r_out_exp     <= 5'd0;
            r_out_swapped <= 1'b0;
            r_out_sticky  <= 1'b0;
        end else begin
            if (w_transfer) begin
                r_a_exp  <= a_exp;
                r_a_mant <= a_mant;
                r_b_exp  <= b_exp;
                r_b_mant <= b_mant;
            end
            if (r_state == S_CMP) begin
                r_swap       <= w_swap;
                r_big_exp    <= w_swap ? r_b_exp  : r_a_exp;
                r_big_mant   <= w_swap ? r_b_mant : r_a_mant;
                r_small_mant <= w_swap ? r_a_mant : r_b_mant;
                r_diff       <= w_diff;
            end
            if (r_state == S_SHIFT) begin
                r_out_big     <= r_big_mant;
                r_out_small   <= w_aligned;
                r_out_exp     <= r_big_exp;
                r_out_swapped <= r_swap;
                r_out_sticky  <= w_sticky;
            end
        end
    end

    assign big_mant   = r_out_big;
    assign small_mant = r_out_small;
    assign exp_out    = r_out_exp;
    assign swapped    = r_out_swapped;
    assign sticky     = r_out_sticky;

endmodule
`default_nettype wire
